// File: rtl/sample_playback_ctrl.sv
// Playback sequencer for the shared reference/error sample RAMs. Issues reads at a programmable
// rate and realigns the fixed-latency RAM outputs into a skid FIFO with a valid/ready head.
module sample_playback_ctrl #(
  parameter int unsigned DATA_SIZE   = 64,
  parameter int unsigned DATA_DEPTH  = 10501,
  parameter int unsigned ADDR_MODULE = 14,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned DIV_WIDTH   = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_loop,
  input  logic [ADDR_MODULE-1:0] i_length,
  input  logic [DIV_WIDTH-1:0]   i_rate_div,
  output logic                   o_mem_en,
  output logic [ADDR_MODULE-1:0] o_mem_addr,
  input  logic [DATA_SIZE-1:0]   i_ref_data,
  input  logic [DATA_SIZE-1:0]   i_err_data,
  output logic [DATA_SIZE-1:0]   o_ref,
  output logic [DATA_SIZE-1:0]   o_err,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_busy,
  output logic                   o_wrap,
  output logic                   o_done
);

  // One slot beyond the credit limit absorbs the read whose enable is still in the output register.
  localparam int unsigned FIFO_DEPTH = RD_LATENCY + 2;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]             state;
  logic [ADDR_MODULE-1:0] last_addr;
  logic [ADDR_MODULE-1:0] start_last;
  logic [ADDR_MODULE-1:0] next_addr;
  logic [DIV_WIDTH-1:0]   rate;
  logic [DIV_WIDTH-1:0]   rate_cnt;
  logic [RD_LATENCY-1:0]  pipe;
  logic [3:0]             inflight;
  logic                   at_last;
  logic                   credit;
  logic                   issue;
  logic                   push;
  logic                   pop;

  logic [DATA_SIZE-1:0] fifo_ref [FIFO_DEPTH];
  logic [DATA_SIZE-1:0] fifo_err [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     fifo_count;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + 4'(pipe[i]);
    end
  end

  always_comb begin
    if (i_length == '0 || 32'(i_length) > DATA_DEPTH) begin
      start_last = ADDR_MODULE'(DATA_DEPTH - 1);
    end else begin
      start_last = i_length - 1'b1;
    end
  end

  assign push      = pipe[RD_LATENCY-1];
  assign o_valid   = (fifo_count != '0);
  assign pop       = o_valid & i_ready;
  assign credit    = (4'(fifo_count) + inflight) < (4'(RD_LATENCY + 1) + 4'(pop));
  assign at_last   = (o_mem_addr == last_addr);
  assign next_addr = at_last ? '0 : o_mem_addr + 1'b1;
  assign issue     = (state == ST_RUN) && (rate_cnt == '0) && credit;
  assign o_busy    = (state != ST_IDLE);
  assign o_ref     = fifo_ref[rd_ptr];
  assign o_err     = fifo_err[rd_ptr];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      o_mem_en   <= 1'b0;
      o_mem_addr <= '0;
      o_wrap     <= 1'b0;
      o_done     <= 1'b0;
      last_addr  <= '0;
      rate       <= '0;
      rate_cnt   <= '0;
      pipe       <= '0;
    end else begin
      o_mem_en <= 1'b0;
      o_wrap   <= 1'b0;
      o_done   <= 1'b0;
      // The RAM samples the address one edge after the enable is registered.
      pipe[0]  <= o_mem_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            last_addr  <= start_last;
            rate       <= i_rate_div;
            rate_cnt   <= i_rate_div;
            o_mem_en   <= 1'b1;
            o_mem_addr <= '0;
            state      <= (start_last == '0 && !i_loop) ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue) begin
            o_mem_en   <= 1'b1;
            o_mem_addr <= next_addr;
            o_wrap     <= at_last;
            rate_cnt   <= rate;
            if (i_stop || (next_addr == last_addr && !i_loop)) begin
              state <= ST_DRAIN;
            end
          end else begin
            if (rate_cnt != '0) begin
              rate_cnt <= rate_cnt - 1'b1;
            end
            if (i_stop) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!o_mem_en && inflight == '0 && fifo_count == '0) begin
            o_done <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_ref[i] <= '0;
        fifo_err[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_ref[wr_ptr] <= i_ref_data;
        fifo_err[wr_ptr] <= i_err_data;
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule
